// File: rtl/rast_pkg.sv
// Shared rasterizer types: subsample encodings, iterator FSM states and the
// subsample-rate-to-step helper.
package rast_pkg;

    typedef enum logic {StWait, StTest} state_e;

    localparam logic [3:0] Sub1x  = 4'b1000;
    localparam logic [3:0] Sub4x  = 4'b0100;
    localparam logic [3:0] Sub16x = 4'b0010;
    localparam logic [3:0] Sub64x = 4'b0001;

    // Sample pitch in fixed point; non-one-hot codes fall back to 1x.
    function automatic int unsigned step_from_sub(input logic [3:0] sub,
                                                  input int unsigned radix);
        int unsigned k;
        case (sub)
            Sub4x:   k = 1;
            Sub16x:  k = 2;
            Sub64x:  k = 3;
            default: k = 0;
        endcase
        return 32'd1 << (radix - k);
    endfunction

endpackage

// File: rtl/iter_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) with enable, used for sample jitter.
// Only compiled when SAMPLE_JITTER_EN is defined.
`ifdef SAMPLE_JITTER_EN
module iter_lfsr #(
    parameter logic [15:0] Seed = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] value
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= Seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule
`endif

// File: rtl/sample_iter.sv
// Walks a triangle's sample-aligned bounding box in row-major order, one sample per cycle.
// Optional SAMPLE_JITTER_EN adds an LFSR-jittered copy of each sample position.
module sample_iter
    import rast_pkg::*;
#(
    parameter int unsigned SIGFIG = 24,
    parameter int unsigned RADIX  = 10,
    parameter int unsigned VERTS  = 3,
    parameter int unsigned AXIS   = 3,
    parameter int unsigned COLORS = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
    input  logic [COLORS-1:0][SIGFIG-1:0]          color_R13U,
    input  logic [1:0][1:0][SIGFIG-1:0]            box_R13S,
    input  logic                                   validTri_R13H,
    input  logic [3:0]                             subSample_RnnnnU,
    output logic                                   halt_RnnnnL,
    output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
    output logic [COLORS-1:0][SIGFIG-1:0]          color_R14U,
    output logic [1:0][SIGFIG-1:0]                 sample_R14S,
`ifdef SAMPLE_JITTER_EN
    output logic [1:0][SIGFIG-1:0]                 jitter_R14S,
`endif
    output logic                                   validSamp_R14H
);

    state_e                                 state_q, state_d;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
    logic [COLORS-1:0][SIGFIG-1:0]          color_q, color_d;
    logic [SIGFIG-1:0]                      ll_x_q, ll_x_d, ur_x_q, ur_x_d, ur_y_q, ur_y_d;
    logic [SIGFIG-1:0]                      step_q, step_d;
    logic [SIGFIG-1:0]                      sx_q, sx_d, sy_q, sy_d;
    logic                                   valid_q, valid_d;

    logic x_end, last, accept, box_ok;

    assign x_end  = $signed(sx_q) >= $signed(ur_x_q);
    assign last   = (state_q == StTest) && x_end && ($signed(sy_q) >= $signed(ur_y_q));
    assign halt_RnnnnL = (state_q == StWait) || last;
    assign accept = validTri_R13H && halt_RnnnnL;
    assign box_ok = ($signed(box_R13S[1][0]) >= $signed(box_R13S[0][0])) &&
                    ($signed(box_R13S[1][1]) >= $signed(box_R13S[0][1]));

    always_comb begin
        state_d = state_q;
        tri_d   = tri_q;
        color_d = color_q;
        ll_x_d  = ll_x_q;
        ur_x_d  = ur_x_q;
        ur_y_d  = ur_y_q;
        step_d  = step_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        valid_d = valid_q;

        // Accept wins over retiring the last sample so back-to-back triangles have no bubble.
        if (accept) begin
            if (box_ok) begin
                tri_d   = tri_R13S;
                color_d = color_R13U;
                ll_x_d  = box_R13S[0][0];
                ur_x_d  = box_R13S[1][0];
                ur_y_d  = box_R13S[1][1];
                step_d  = SIGFIG'(step_from_sub(subSample_RnnnnU, RADIX));
                sx_d    = box_R13S[0][0];
                sy_d    = box_R13S[0][1];
                valid_d = 1'b1;
                state_d = StTest;
            end else begin
                valid_d = 1'b0;
                state_d = StWait;
            end
        end else if (state_q == StTest) begin
            if (last) begin
                valid_d = 1'b0;
                state_d = StWait;
            end else if (x_end) begin
                sx_d = ll_x_q;
                sy_d = sy_q + step_q;
            end else begin
                sx_d = sx_q + step_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StWait;
            tri_q   <= '0;
            color_q <= '0;
            ll_x_q  <= '0;
            ur_x_q  <= '0;
            ur_y_q  <= '0;
            step_q  <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tri_q   <= tri_d;
            color_q <= color_d;
            ll_x_q  <= ll_x_d;
            ur_x_q  <= ur_x_d;
            ur_y_q  <= ur_y_d;
            step_q  <= step_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            valid_q <= valid_d;
        end
    end

    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S[0] = sx_q;
    assign sample_R14S[1] = sy_q;
    assign validSamp_R14H = valid_q;

`ifdef SAMPLE_JITTER_EN
    logic [15:0]       lfsr;
    logic [SIGFIG-1:0] off_x, off_y;

    iter_lfsr #(
        .Seed(16'hACE1)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (valid_q),
        .value(lfsr)
    );

    // 8-bit fraction of a step, so the offset stays in [0, step).
    assign off_x = SIGFIG'(({{SIGFIG{1'b0}}, lfsr[7:0]} * {8'd0, step_q}) >> 8);
    assign off_y = SIGFIG'(({{SIGFIG{1'b0}}, lfsr[15:8]} * {8'd0, step_q}) >> 8);
    assign jitter_R14S[0] = sx_q + off_x;
    assign jitter_R14S[1] = sy_q + off_y;
`endif

endmodule

// File: doc/sample_iter.md
# sample_iter

Sample iterator that walks a triangle's sample-grid-aligned bounding box in row-major order and emits one sample location per cycle, together with the held triangle and color, to the sample test stage. It sits between the bounding-box stage (R13) and the sample test stage (R14 inputs). It applies back-pressure upstream and has no downstream stall, because the sample test stage always accepts.

## Interface
Parameters:
- SIGFIG, 24: bits in position and color.
- RADIX, 10: fraction bits; 1.0 pixel = 1<<RADIX.
- VERTS, 3: vertices per triangle.
- AXIS, 3: axes per vertex (x,y,z).
- COLORS, 3: color channels.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low (asserted at 0).
- tri_R13S  in  [VERTS][AXIS]×SIGFIG signed  incoming triangle.
- color_R13U  in  [COLORS]×SIGFIG  triangle color.
- box_R13S  in  [2][2]×SIGFIG signed  box[0]=lower-left (x,y), box[1]=upper-right; both on the sample grid.
- validTri_R13H  in  1  triangle and box are valid.
- subSample_RnnnnU  in  4  one-hot MSAA rate: 1000=1x, 0100=4x, 0010=16x, 0001=64x.
- halt_RnnnnL  out  1  1 = upstream may transfer this cycle; 0 = hold.
- tri_R14S  out  [VERTS][AXIS]×SIGFIG  held triangle.
- color_R14U  out  [COLORS]×SIGFIG  held color.
- sample_R14S  out  [2]×SIGFIG signed  current sample (x,y).
- validSamp_R14H  out  1  sample_R14S is valid.

## Operation
- FSM states: WAIT (idle, no sample in flight) and TEST (emitting samples).
- step = 1<<(RADIX−k), where k = 0, 1, 2, 3 for 1x, 4x, 16x, 64x. subSample_RnnnnU is latched when a triangle is accepted.
- last = (state==TEST) && sample.x ≥ box[1].x && sample.y ≥ box[1].y.
- halt_RnnnnL = (state==WAIT) || last. It is combinational from registers only.
- Accept: a transfer occurs when validTri_R13H && halt_RnnnnL.
  - If the box is valid (ur.x ≥ ll.x and ur.y ≥ ll.y): latch tri, color, box and step; sample ← box[0]; validSamp ← 1; state ← TEST.
  - If the box is invalid: the triangle is consumed and dropped. No samples are emitted. State ← WAIT.
- In TEST with no accept:
  - If last: validSamp ← 0; state ← WAIT.
  - Else if sample.x ≥ box[1].x: x ← box[0].x; y ← y+step.
  - Else: x ← x+step.
- Last sample plus a simultaneous new valid triangle: the accept takes priority. The new triangle's first sample follows the old triangle's last sample with no bubble.
- Arithmetic is SIGFIG-wide signed addition. The box lies within screen range, so overflow is not checked.

## Timing
- Latency: 1 cycle from accept to the first validSamp_R14H.
- Samples per triangle = ((ur.x−ll.x)/step+1)·((ur.y−ll.y)/step+1). They are emitted on consecutive cycles.
- Reset values: state WAIT; validSamp_R14H 0; sample_R14S, tri_R14S, color_R14U all 0. halt_RnnnnL reads 1 while in reset and after reset.
- Reset mid-triangle: validSamp drops immediately (asynchronous). After release the FSM is in WAIT, and the abandoned triangle is not resumed.
- Upstream must hold tri/color/box/validTri stable while halt_RnnnnL = 0.

## Configuration
- SAMPLE_JITTER_EN defined:
  - Adds output jitter_R14S [2]×SIGFIG signed.
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances on every cycle with validSamp_R14H=1.
  - jitter.x = sample.x + ((lfsr[7:0]·step)>>8); jitter.y = sample.y + ((lfsr[15:8]·step)>>8). The offset lies in [0, step).
  - sample_R14S remains unjittered.
- SAMPLE_JITTER_EN undefined: the port and the LFSR are absent. All other behaviour is identical.

## Structure
- Shared package rast_pkg holds:
  - the one-hot subsample encodings;
  - the state enum typedef (WAIT, TEST);
  - a step-from-subsample function.
- One sub-module, iter_lfsr (16-bit LFSR with enable), instantiated only under SAMPLE_JITTER_EN.

## Test plan
- 1x, box (0,0)–(2048,1024) → samples (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024) on 6 consecutive cycles. halt_RnnnnL is 0 on the first 5 cycles and 1 on the 6th.
- 4x, box (512,512)–(512,512) → exactly one sample (512,512). halt_RnnnnL = 1 in that same cycle.
- Two triangles back-to-back, validTri held high, 1x boxes of 2 samples each → 4 consecutive validSamp cycles with no bubble. tri_R14S switches on the 3rd sample.
- Box ur.x < ll.x → triangle consumed, validSamp stays 0, halt_RnnnnL stays 1.
- 1x 6-sample box, rst=0 during the 3rd sample → validSamp 0 immediately. After release: halt_RnnnnL=1 and no further samples.
- SAMPLE_JITTER_EN, 16x (step 256), box (0,0)–(768,768) → 16 samples, each with sample ≤ jitter < sample+256 per axis. The first jitter equals the seed-derived offset.
